mem_tile_addr_gen: RTL and testbench

Parametrised read-address generator for operand matrices stored row-major in the local memory.
- Walks a rows x cols matrix in memory-word strips.
  - Column-strip order serves the B operand.
  - Row-strip order serves the A operand.
- Optionally repeats the whole walk.
- Issues one address per cycle over a valid/ready handshake to the address FIFO.
- Sits between the config module and the memory read port, one instance per operand.

---
 rtl/mm_addr_pkg.sv | 30 +++
 rtl/nested_loop_counter.sv | 44 ++++
 rtl/mem_tile_addr_gen.sv | 168 ++++++++++++++++
 tb/tb_mem_tile_addr_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_addr_pkg.sv
// Shared types and elaboration-time helpers for the operand matrix
// address generator.
package mm_addr_pkg;

  typedef enum logic {
    COL_STRIP = 1'b0,
    ROW_STRIP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Exact log2 of a power-of-two value; widths here never exceed 2^30.
  function automatic int log2_pow2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) == value) result = i;
    end
    return result;
  endfunction

  function automatic int elements_per_word(input int mem_bytes, input int data_bytes);
    return mem_bytes / data_bytes;
  endfunction

endpackage

// File: rtl/nested_loop_counter.sv
// Two-level index counter: inner index wraps at inner_max and carries into
// the outer index; flags mark the final inner, outer and combined position.
module nested_loop_counter #(
  parameter int INNER_WIDTH = 16,
  parameter int OUTER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   en,
  input  logic [INNER_WIDTH-1:0] inner_max,
  input  logic [OUTER_WIDTH-1:0] outer_max,
  output logic                   inner_last,
  output logic                   outer_last,
  output logic                   last
);

  logic [INNER_WIDTH-1:0] inner_count;
  logic [OUTER_WIDTH-1:0] outer_count;

  assign inner_last = (inner_count == inner_max);
  assign outer_last = (outer_count == outer_max);
  assign last       = inner_last && outer_last;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inner_count <= '0;
      outer_count <= '0;
    end else if (clear) begin
      inner_count <= '0;
      outer_count <= '0;
    end else if (en) begin
      if (inner_last) begin
        inner_count <= '0;
        outer_count <= outer_last ? '0 : outer_count + 1'b1;
      end else begin
        inner_count <= inner_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_tile_addr_gen.sv
// Read-address generator walking a row-major matrix in memory-word strips,
// one address per handshake, optionally repeating the whole walk.
module mem_tile_addr_gen
  import mm_addr_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DIM_WIDTH            = 16,
  parameter int DATA_WIDTH_BYTES     = 1,
  parameter int MEM_DATA_WIDTH_BYTES = 32,
  parameter int REP_WIDTH            = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  mode_i,
  input  logic [DIM_WIDTH-1:0]  rows_i,
  input  logic [DIM_WIDTH-1:0]  cols_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [REP_WIDTH-1:0]  repeat_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ELEMENTS   = elements_per_word(MEM_DATA_WIDTH_BYTES, DATA_WIDTH_BYTES);
  localparam int ELEM_SHIFT = log2_pow2(ELEMENTS);
  localparam int DATA_SHIFT = log2_pow2(DATA_WIDTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STRIP_STEP = ADDR_WIDTH'(MEM_DATA_WIDTH_BYTES);
  localparam logic [DIM_WIDTH:0]    ELEM_ROUND = (DIM_WIDTH+1)'(ELEMENTS - 1);

  state_e state, state_next;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] inner_step_r;
  logic [ADDR_WIDTH-1:0] outer_step_r;
  logic [DIM_WIDTH-1:0]  inner_max_r;
  logic [DIM_WIDTH-1:0]  outer_max_r;
  logic [REP_WIDTH-1:0]  repeat_r;

  // Derived walk geometry from the live config inputs, captured on start.
  mode_e                 mode_sel;
  logic [DIM_WIDTH:0]    cols_rounded;
  logic [DIM_WIDTH-1:0]  strips;
  logic [DIM_WIDTH-1:0]  rows_max;
  logic [DIM_WIDTH-1:0]  strips_max;
  logic [ADDR_WIDTH-1:0] row_step;
  logic                  zero_dim;

  assign mode_sel     = mode_e'(mode_i);
  assign cols_rounded = {1'b0, cols_i} + ELEM_ROUND;
  assign strips       = DIM_WIDTH'(cols_rounded >> ELEM_SHIFT);
  assign rows_max     = rows_i - 1'b1;
  assign strips_max   = strips - 1'b1;
  assign row_step     = ADDR_WIDTH'(cols_i) << DATA_SHIFT;
  assign zero_dim     = (rows_i == '0) || (cols_i == '0);

  logic start_go;
  logic handshake;
  logic loop_inner_last;
  logic loop_outer_last;
  logic loop_last;
  logic pass_last;
  logic unused_pass_flags;

  assign start_go  = (state == IDLE) && start_i;
  assign handshake = (state == RUN) && addr_ready_i;

  nested_loop_counter #(
    .INNER_WIDTH (DIM_WIDTH),
    .OUTER_WIDTH (DIM_WIDTH)
  ) u_loop_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_go),
    .en         (handshake),
    .inner_max  (inner_max_r),
    .outer_max  (outer_max_r),
    .inner_last (loop_inner_last),
    .outer_last (loop_outer_last),
    .last       (loop_last)
  );

  // Single-level use: passes live in the inner index, outer index is fixed.
  nested_loop_counter #(
    .INNER_WIDTH (REP_WIDTH),
    .OUTER_WIDTH (1)
  ) u_pass_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_go),
    .en         (handshake && loop_last),
    .inner_max  (repeat_r),
    .outer_max  (1'b0),
    .inner_last (pass_last),
    .outer_last (unused_pass_flags),
    .last       ()
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_i) state_next = zero_dim ? DONE : RUN;
      RUN: begin
        if (abort_i) state_next = IDLE;
        else if (handshake && loop_last && pass_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_r       <= '0;
      line_base    <= '0;
      base_r       <= '0;
      inner_step_r <= '0;
      outer_step_r <= '0;
      inner_max_r  <= '0;
      outer_max_r  <= '0;
      repeat_r     <= '0;
    end else begin
      state <= state_next;
      if (start_go) begin
        addr_r    <= base_addr_i;
        line_base <= base_addr_i;
        base_r    <= base_addr_i;
        repeat_r  <= repeat_i;
        if (mode_sel == COL_STRIP) begin
          inner_step_r <= row_step;
          outer_step_r <= STRIP_STEP;
          inner_max_r  <= rows_max;
          outer_max_r  <= strips_max;
        end else begin
          inner_step_r <= STRIP_STEP;
          outer_step_r <= row_step;
          inner_max_r  <= strips_max;
          outer_max_r  <= rows_max;
        end
      end else if (handshake) begin
        // Inner step within a line, hop to the next line, or rewind a pass.
        if (!loop_inner_last) begin
          addr_r <= addr_r + inner_step_r;
        end else if (!loop_outer_last) begin
          line_base <= line_base + outer_step_r;
          addr_r    <= line_base + outer_step_r;
        end else begin
          line_base <= base_r;
          addr_r    <= base_r;
        end
      end
    end
  end

  assign addr_o       = addr_r;
  assign addr_valid_o = (state == RUN);
  assign busy_o       = (state == RUN);
  assign done_o       = (state == DONE);

endmodule

// File: tb/tb_mem_tile_addr_gen.sv
// Directed bench for mem_tile_addr_gen: strip orders, repeat, stalls,
// degenerate sizes, address wrap, abort and asynchronous reset.
module tb_mem_tile_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] rows_i = '0;
  logic [15:0] cols_i = '0;
  logic [15:0] base_addr_i = '0;
  logic [7:0]  repeat_i = '0;
  logic [15:0] addr_o;
  logic        addr_valid_o;
  logic        addr_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_addr [0:15];

  mem_tile_addr_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .mode_i       (mode_i),
    .rows_i       (rows_i),
    .cols_i       (cols_i),
    .base_addr_i  (base_addr_i),
    .repeat_i     (repeat_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a walk and consumes it, comparing each accepted address with exp_addr.
  task automatic run_walk(input string name, input logic mode, input logic [15:0] rows,
                          input logic [15:0] cols, input logic [15:0] base,
                          input logic [7:0] rep, input bit rand_ready, input int n_exp);
    int          idx = 0;
    int          dones = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = '0;
    mode_i = mode; rows_i = rows; cols_i = cols; base_addr_i = base; repeat_i = rep;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    while (dones == 0 && cyc < 300) begin
      addr_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        checks++;
        if (addr_valid_o !== 1'b1 || addr_o !== prev_addr) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b addr=%h required valid=1 addr=%h",
                   name, addr_valid_o, addr_o, prev_addr);
        end
      end
      if (done_o === 1'b1) begin
        dones++;
        checks++;
        if (addr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done_cycle: valid=%b busy=%b required 0 0", name, addr_valid_o, busy_o);
        end
      end
      if (addr_valid_o === 1'b1 && addr_ready_i) begin
        checks++;
        if (idx >= n_exp) begin
          errors++;
          $display("FAIL %s extra_addr: got addr=%h after %0d required addresses", name, addr_o, n_exp);
        end else if (addr_o !== exp_addr[idx]) begin
          errors++;
          $display("FAIL %s addr[%0d]: got %h required %h", name, idx, addr_o, exp_addr[idx]);
        end
        idx++;
      end
      prev_stall = addr_valid_o && !addr_ready_i;
      prev_addr  = addr_o;
      if (dones == 0) begin
        step();
        cyc++;
      end
    end
    addr_ready_i = 1'b0;
    checks++;
    if (dones != 1 || idx != n_exp) begin
      errors++;
      $display("FAIL %s walk_end: done_seen=%0d addrs=%0d required done_seen=1 addrs=%0d",
               name, dones, idx, n_exp);
    end
    if (!rand_ready) begin
      checks++;
      if (cyc != n_exp) begin
        errors++;
        $display("FAIL %s done_latency: done after %0d cycles required %0d", name, cyc, n_exp);
      end
    end
    step();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || addr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b required 0 0 0",
               name, done_o, busy_o, addr_valid_o);
    end
  endtask

  task automatic load_col_sequence();
    exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0140; exp_addr[2] = 16'h0180; exp_addr[3] = 16'h01C0;
    exp_addr[4] = 16'h0120; exp_addr[5] = 16'h0160; exp_addr[6] = 16'h01A0; exp_addr[7] = 16'h01E0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++;
    if (addr_o !== 16'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: addr=%h valid=%b busy=%b done=%b required 0 0 0 0",
               addr_o, addr_valid_o, busy_o, done_o);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_col_strip();
    load_col_sequence();
    run_walk("col_strip", 1'b0, 16'd4, 16'd64, 16'h0100, 8'd0, 1'b0, 8);
  endtask

  task automatic test_row_strip_repeat();
    for (int i = 0; i < 8; i++) exp_addr[i] = 16'h0100 + 16'(32 * (i % 4));
    run_walk("row_repeat", 1'b1, 16'd2, 16'd64, 16'h0100, 8'd1, 1'b0, 8);
  endtask

  task automatic test_stall();
    // cols=40 bytes per row, two strips of 32 bytes
    exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0128; exp_addr[2] = 16'h0150;
    exp_addr[3] = 16'h0120; exp_addr[4] = 16'h0148; exp_addr[5] = 16'h0170;
    run_walk("stall", 1'b0, 16'd3, 16'd40, 16'h0100, 8'd0, 1'b1, 6);
  endtask

  task automatic test_zero_dims();
    run_walk("zero_rows", 1'b0, 16'd0, 16'd64, 16'h0100, 8'd0, 1'b0, 0);
    run_walk("zero_cols", 1'b1, 16'd5, 16'd0, 16'h0100, 8'd2, 1'b0, 0);
  endtask

  task automatic test_wrap();
    exp_addr[0] = 16'hFFE0; exp_addr[1] = 16'h0000;
    run_walk("wrap", 1'b1, 16'd1, 16'd64, 16'hFFE0, 8'd0, 1'b0, 2);
  endtask

  task automatic test_abort_reset();
    int done_hits = 0;
    load_col_sequence();
    mode_i = 1'b0; rows_i = 16'd4; cols_i = 16'd64; base_addr_i = 16'h0100; repeat_i = 8'd0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    addr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_o !== exp_addr[i] || addr_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL abort_pre[%0d]: addr=%h valid=%b required %h 1", i, addr_o, addr_valid_o, exp_addr[i]);
      end
      step();
    end
    // Stall with a start pulse that must be ignored while busy.
    addr_ready_i = 1'b0;
    start_i = 1'b1;
    base_addr_i = 16'h0800;
    step();
    start_i = 1'b0;
    checks++;
    if (addr_o !== 16'h01C0 || addr_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: addr=%h valid=%b busy=%b required 01c0 1 1",
               addr_o, addr_valid_o, busy_o);
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    checks++;
    if (addr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: valid=%b busy=%b required 0 0", addr_valid_o, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (done_o === 1'b1 || addr_valid_o === 1'b1) done_hits++;
      step();
    end
    checks++;
    if (done_hits != 0) begin
      errors++;
      $display("FAIL abort_quiet: done/valid seen %0d cycles required 0", done_hits);
    end
    // Second run, reset asserted between clock edges.
    base_addr_i = 16'h0100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    addr_ready_i = 1'b1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (addr_o !== 16'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: addr=%h valid=%b busy=%b done=%b required 0 0 0 0",
               addr_o, addr_valid_o, busy_o, done_o);
    end
    addr_ready_i = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    run_walk("after_reset", 1'b0, 16'd4, 16'd64, 16'h0100, 8'd0, 1'b0, 8);
  endtask

  initial begin
    test_reset();
    test_col_strip();
    test_row_strip_repeat();
    test_stall();
    test_zero_dims();
    test_wrap();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
